// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the M-extension multiply/divide unit.
package muldiv_pkg;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] FN7_MULDIV = 7'b0000001;
   localparam logic [2:0] MD_MUL     = 3'd0;
   localparam logic [2:0] MD_MULH    = 3'd1;
   localparam logic [2:0] MD_MULHSU  = 3'd2;
   localparam logic [2:0] MD_MULHU   = 3'd3;
   localparam logic [2:0] MD_DIV     = 3'd4;
   localparam logic [2:0] MD_DIVU    = 3'd5;
   localparam logic [2:0] MD_REM     = 3'd6;
   localparam logic [2:0] MD_REMU    = 3'd7;
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} md_state_e;
endpackage

// File: rtl/md_iter_core.sv
// md_iter_core: radix-2 shift-add multiplier / restoring divider on unsigned magnitudes.
// The divider datapath is only built when MULDIV_DIV_EN is defined.
module md_iter_core #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              kill_i,
   input  logic              start_i,
   input  logic              div_i,
   input  logic [XLEN-1:0]   a_i,
   input  logic [XLEN-1:0]   b_i,
   output logic              done_o,
   output logic [2*XLEN-1:0] acc_o
);
   localparam int CW = $clog2(XLEN) + 1;
   logic [2*XLEN-1:0] acc_q, mul_nx, div_nx;
   logic [XLEN-1:0]   m_q;
   logic [CW-1:0]     cnt_q;
   logic              run_q, div_q;
   logic [XLEN:0]     sum;
   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   assign sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
   assign mul_nx = {sum, acc_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
   logic [XLEN:0] trial, diff;
   assign trial  = acc_q[2*XLEN-1:XLEN-1];
   assign diff   = trial - {1'b0, m_q};
   assign div_nx = diff[XLEN] ? {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
`else
   // divide ops never start the core in this build
   assign div_nx = mul_nx;
`endif
   assign done_o = run_q && cnt_q == CW'(XLEN);
   assign acc_o  = acc_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         acc_q <= '0;
         m_q   <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
         div_q <= 1'b0;
      end else if (kill_i) begin
         run_q <= 1'b0;
      end else if (start_i) begin
         acc_q <= {{XLEN{1'b0}}, a_i};
         m_q   <= b_i;
         cnt_q <= '0;
         run_q <= 1'b1;
         div_q <= div_i;
      end else if (run_q && !done_o) begin
         acc_q <= div_q ? div_nx : mul_nx;
         cnt_q <= cnt_q + 1'b1;
      end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M/RV64M multiply/divide unit with valid/ready handshake and tagged result.
// Define MULDIV_DIV_EN to build the divider; otherwise divide ops complete at once with result 0.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   output logic             md_hit,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  rs1,
   input  logic [XLEN-1:0]  rs2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);
   md_state_e         state_q, state_d;
   logic [XLEN-1:0]   out_result_q, out_result_d, mag_a, mag_b, spec_val, narrow, fixed;
   logic [TAG_W-1:0]  tag_q;
   logic              sel_hi_q, neg_q, div_q;
   logic              accept, is_div, sgn_a, sgn_b, sel_hi, neg, special, core_done;
   logic [2*XLEN-1:0] acc, wide;
   assign md_hit     = opcode == OPC_OP && funct7 == FN7_MULDIV;
   assign in_ready   = state_q == S_IDLE;
   assign busy       = state_q != S_IDLE;
   assign out_valid  = state_q == S_DONE;
   assign out_result = out_result_q;
   assign out_tag    = tag_q;
   assign accept     = in_valid && in_ready && md_hit && !flush;
   assign is_div     = funct3[2];
   // rs1 signed for MUL/MULH/MULHSU/DIV/REM; rs2 signed for MUL/MULH/DIV/REM
   assign sgn_a  = rs1[XLEN-1] && (!funct3[0] || funct3 == MD_MULH);
   assign sgn_b  = rs2[XLEN-1] && (funct3 == MD_MULH || (!funct3[0] && funct3 != MD_MULHSU));
   assign mag_a  = sgn_a ? -rs1 : rs1;
   assign mag_b  = sgn_b ? -rs2 : rs2;
   assign sel_hi = is_div ? funct3[1] : funct3[1:0] != 2'b00;
   assign neg    = (is_div && funct3[1]) ? sgn_a : sgn_a ^ sgn_b;
`ifdef MULDIV_DIV_EN
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
   logic div0, ovf;
   assign div0     = is_div && rs2 == '0;
   assign ovf      = is_div && !funct3[0] && rs1 == MIN_NEG && rs2 == '1;
   assign special  = div0 || ovf;
   assign spec_val = div0 ? (funct3[1] ? rs1 : '1) : (funct3[1] ? '0 : MIN_NEG);
`else
   assign special  = is_div;
   assign spec_val = '0;
`endif
   md_iter_core #(.XLEN(XLEN)) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .kill_i  (flush),
      .start_i (accept && !special),
      .div_i   (is_div),
      .a_i     (mag_a),
      .b_i     (mag_b),
      .done_o  (core_done),
      .acc_o   (acc)
   );
   // products negate across the full 2*XLEN width; quotient/remainder negate alone
   assign wide   = neg_q ? -acc : acc;
   assign narrow = sel_hi_q ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
   assign fixed  = div_q ? (neg_q ? -narrow : narrow)
                         : (sel_hi_q ? wide[2*XLEN-1:XLEN] : wide[XLEN-1:0]);
   always_comb begin
      state_d      = state_q;
      out_result_d = out_result_q;
      case (state_q)
         S_IDLE: if (accept) begin
            state_d      = special ? S_DONE : (is_div ? S_DIV : S_MUL);
            out_result_d = spec_val;
         end
         S_MUL, S_DIV: if (core_done) begin
            state_d      = S_DONE;
            out_result_d = fixed;
         end
         default: state_d = out_ready ? S_IDLE : S_DONE;
      endcase
      if (flush) state_d = S_IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q      <= S_IDLE;
         out_result_q <= '0;
         tag_q        <= '0;
         sel_hi_q     <= 1'b0;
         neg_q        <= 1'b0;
         div_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_result_q <= out_result_d;
         if (accept) begin
            tag_q    <= in_tag;
            sel_hi_q <= sel_hi;
            neg_q    <= neg;
            div_q    <= is_div;
         end
      end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a result/tag scoreboard drained by an output monitor.
module tb_muldiv_unit;
   localparam int XLEN = 32, TAG_W = 5, NL = XLEN + 1;
   localparam logic [2:0] MUL = 0, MULH = 1, MULHSU = 2, MULHU = 3, DIV = 4, DIVU = 5, REM = 6, REMU = 7;
`ifdef MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif
   localparam int DL = DIV_EN ? NL : 0;
   logic             clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
   logic [6:0]       opcode = 7'b0110011, funct7 = 7'b0000001;
   logic [2:0]       funct3 = 0;
   logic [XLEN-1:0]  rs1 = 0, rs2 = 0;
   logic [TAG_W-1:0] in_tag = 0;
   logic             md_hit, in_ready, out_valid, busy;
   logic [XLEN-1:0]  out_result;
   logic [TAG_W-1:0] out_tag;
   logic [TAG_W+XLEN-1:0] exp_q[$];
   int checks = 0, fails = 0;
   always #5 clk = ~clk;
   muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .md_hit(md_hit), .in_valid(in_valid), .in_ready(in_ready), .rs1(rs1), .rs2(rs2), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .busy(busy)
   );
   function automatic logic [31:0] dv(input logic [31:0] v);
      return DIV_EN ? v : 32'h0;
   endfunction
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask
   always @(negedge clk)
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("unexpected_output", {out_tag, out_result}, 0);
         else begin
            logic [TAG_W+XLEN-1:0] e;
            e = exp_q.pop_front();
            chk("result", out_result, e[XLEN-1:0]);
            chk("tag", out_tag, e[TAG_W+XLEN-1:XLEN]);
         end
      end
   task automatic issue(input logic [2:0] f, input logic [31:0] a, b, input logic [4:0] t,
                        input logic [31:0] e, input bit push);
      @(negedge clk);
      funct3 = f; rs1 = a; rs2 = b; in_tag = t; in_valid = 1;
      chk("in_ready_before_issue", in_ready, 1);
      @(posedge clk); #1 in_valid = 0;
      if (push) exp_q.push_back({t, e});
   endtask
   task automatic wait_valid(input int lat, input string name);
      int n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, n, lat);
   endtask
   task automatic run(input logic [2:0] f, input logic [31:0] a, b, input logic [4:0] t,
                      input logic [31:0] e, input int lat, input string name);
      issue(f, a, b, t, e, 1);
      wait_valid(lat, name);
      @(posedge clk); #1;
   endtask
   initial begin
      bit seen;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk) rst_n = 1;
      #1 chk("rst_in_ready", in_ready, 1);
      chk("md_hit_m", md_hit, 1);
      @(negedge clk) funct7 = 0; in_valid = 1;
      #1 chk("md_hit_alu", md_hit, 0);
      @(posedge clk); #1 chk("non_m_ignored", busy, 0);
      in_valid = 0; funct7 = 7'b0000001;
      run(MUL, 7, 32'hFFFFFFFD, 5, 32'hFFFFFFEB, NL, "lat_mul");
      run(MULH, 32'h80000000, 32'h80000000, 6, 32'h40000000, NL, "lat_mulh");
      run(MULHU, 32'h80000000, 32'h80000000, 7, 32'h40000000, NL, "lat_mulhu");
      run(MULHSU, 32'h80000000, 32'h80000000, 8, 32'hC0000000, NL, "lat_mulhsu");
      run(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 10, 32'h1, NL, "lat_mul_m1");
      run(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 11, 32'hFFFFFFFE, NL, "lat_mulhu_max");
      run(MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 12, 32'h0, NL, "lat_mulh_m1");
      run(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 13, 32'hFFFFFFFF, NL, "lat_mulhsu_m1");
      run(DIV, 32'h80000000, 32'hFFFFFFFF, 14, dv(32'h80000000), 0, "lat_div_ovf");
      run(REM, 32'h80000000, 32'hFFFFFFFF, 15, 32'h0, 0, "lat_rem_ovf");
      run(DIVU, 32'h64, 0, 16, dv(32'hFFFFFFFF), 0, "lat_divu_zero");
      run(REMU, 32'h64, 0, 17, dv(32'h64), 0, "lat_remu_zero");
      run(DIV, 32'hFFFFFFEC, 6, 18, dv(32'hFFFFFFFD), DL, "lat_div");
      out_ready = 0;
      issue(REM, 32'hFFFFFFEC, 6, 3, dv(32'hFFFFFFFE), 1);
      wait_valid(DL, "lat_rem_stall");
      repeat (5) begin
         @(posedge clk); #1;
         chk("stall_valid", out_valid, 1);
         chk("stall_result", out_result, dv(32'hFFFFFFFE));
         chk("stall_tag", out_tag, 3);
         chk("stall_in_ready", in_ready, 0);
      end
      out_ready = 1;
      @(posedge clk); #1;
      run(DIVU, 9, 3, 19, dv(32'h3), DL, "lat_divu");
      run(DIVU, 100, 7, 20, dv(32'd14), DL, "lat_divu2");
      run(REMU, 100, 7, 21, dv(32'd2), DL, "lat_remu");
      run(DIV, 7, 32'hFFFFFFFE, 22, dv(32'hFFFFFFFD), DL, "lat_div_negdvs");
      run(REM, 7, 32'hFFFFFFFE, 23, dv(32'h1), DL, "lat_rem_negdvs");
      issue(MUL, 12, 13, 9, 0, 0);
      repeat (10) @(posedge clk);
      @(negedge clk) flush = 1;
      @(posedge clk); #1 flush = 0;
      chk("flush_busy", busy, 0);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         seen |= out_valid;
      end
      chk("flush_no_valid", seen, 0);
      @(negedge clk) funct3 = MUL; in_valid = 1; flush = 1;
      @(posedge clk); #1 in_valid = 0; flush = 0;
      chk("flush_beats_accept", busy, 0);
      run(MUL, 12, 13, 24, 32'd156, NL, "lat_mul_after_flush");
      out_ready = 0;
      issue(DIVU, 100, 7, 25, 0, 0);
      repeat (5) @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_out_result", out_result, 0);
      chk("arst_out_tag", out_tag, 0);
      @(negedge clk) rst_n = 1; out_ready = 1;
      run(MUL, 3, 5, 26, 32'd15, NL, "lat_mul_after_reset");
      repeat (10) if (exp_q.size() != 0) @(posedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
